// File: rtl/spi_slave_phy_if.sv
// Signal bundle between the SPI slave front end and its pins / state machine.
// The slave modport is the PHY's view; the master modport drives it.
interface spi_slave_phy_if;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_csn;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [31:0] tx_data;
    logic        csn_sync;
    logic [6:0]  bit_cnt;
    logic [31:0] rx_data;
    logic        word_valid;
    logic        frame_error;

    modport slave (
        input  spi_sclk, spi_mosi, spi_csn, tx_data,
        output spi_miso, spi_miso_oe, csn_sync, bit_cnt, rx_data, word_valid, frame_error
    );

    modport master (
        output spi_sclk, spi_mosi, spi_csn, tx_data,
        input  spi_miso, spi_miso_oe, csn_sync, bit_cnt, rx_data, word_valid, frame_error
    );
endinterface

// File: rtl/spi_slave_phy.sv
// Oversampled mode-0 SPI slave front end: synchronises the pins, deserialises
// MOSI into 32-bit words and serialises the read word onto MISO.
module spi_slave_phy #(
    parameter int SYNC_STAGES = 2,
    parameter bit MISO_IDLE   = 1'b0
) (
    input  logic           clock,
    input  logic           nreset,
    spi_slave_phy_if.slave bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [6:0] CNT_ZERO  = 7'd0;
    localparam logic [6:0] CNT_ADDR  = 7'd32;
    localparam logic [6:0] CNT_BURST = 7'd33;
    localparam logic [6:0] CNT_FULL  = 7'd64;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic                   sclk_d;

    logic [0:0]  state;
    logic [6:0]  bit_cnt;
    logic [30:0] rx_shift;
    logic [30:0] tx_shift;
    logic [31:0] rx_data;
    logic        word_valid;
    logic        frame_error;
    logic        miso;
    logic        miso_oe;

    logic        sclk_s;
    logic        mosi_s;
    logic        csn_s;
    logic        sclk_rise;
    logic        sclk_fall;
    logic [6:0]  bit_cnt_next;
    logic [31:0] rx_word;
    logic        word_done;
    logic        at_boundary;

    // NOTE: every register below is written with <= so that all flops sample
    // the same pre-edge values; blocking writes here would create order races.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            csn_sync_q <= '1;
            sclk_d     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], bus.spi_csn};
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];

    // Edges count only inside an open frame; a closing csn outranks them below.
    assign sclk_rise = (state == ST_ACTIVE) &&  sclk_s && !sclk_d;
    assign sclk_fall = (state == ST_ACTIVE) && !sclk_s &&  sclk_d;

    // NOTE: each combinational output gets a default first so no path leaves
    // it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        bit_cnt_next = bit_cnt + 7'd1;
        if (bit_cnt == CNT_FULL) begin
            bit_cnt_next = CNT_BURST;
        end
        rx_word     = {rx_shift, mosi_s};
        word_done   = (bit_cnt_next == CNT_ADDR) || (bit_cnt_next == CNT_FULL);
        at_boundary = (bit_cnt == CNT_ZERO) || (bit_cnt == CNT_ADDR) || (bit_cnt == CNT_FULL);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_IDLE;
            bit_cnt     <= CNT_ZERO;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            miso        <= MISO_IDLE;
            miso_oe     <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!csn_s) begin
                        state    <= ST_ACTIVE;
                        bit_cnt  <= CNT_ZERO;
                        rx_shift <= '0;
                        tx_shift <= '0;
                        miso     <= MISO_IDLE;
                        miso_oe  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (csn_s) begin
                        // Partial word is dropped; rx_data keeps the last full word.
                        state       <= ST_IDLE;
                        bit_cnt     <= CNT_ZERO;
                        miso        <= MISO_IDLE;
                        miso_oe     <= 1'b0;
                        frame_error <= !at_boundary;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_word[30:0];
                        bit_cnt  <= bit_cnt_next;
                        if (word_done) begin
                            rx_data    <= rx_word;
                            word_valid <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt < CNT_ADDR) begin
                            miso <= MISO_IDLE;
                        end else if ((bit_cnt == CNT_ADDR) || (bit_cnt == CNT_FULL)) begin
                            // Read word is captured once here and not tracked afterwards.
                            tx_shift <= bus.tx_data[30:0];
                            miso     <= bus.tx_data[31];
                        end else begin
                            tx_shift <= {tx_shift[29:0], 1'b0};
                            miso     <= tx_shift[30];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.csn_sync    = (state == ST_IDLE);
    assign bus.bit_cnt     = bit_cnt;
    assign bus.rx_data     = rx_data;
    assign bus.word_valid  = word_valid;
    assign bus.frame_error = frame_error;
    assign bus.spi_miso    = miso;
    assign bus.spi_miso_oe = miso_oe;

endmodule

// File: tb/tb_spi_slave_phy.sv
// Directed bench for spi_slave_phy: write, read, burst, abort, collision,
// idle-clock, 4x-ratio and mid-frame reset scenarios.
module tb_spi_slave_phy;
    logic clock;
    logic nreset;
    int   checks;
    int   failures;
    int   wv_count;
    int   fe_count;
    int   wv_base;
    int   fe_base;

    spi_slave_phy_if bus ();

    spi_slave_phy #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.word_valid === 1'b1) wv_count++;
        if (bus.frame_error === 1'b1) fe_count++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Sends the top nbits of w MSB first; returns the MISO bits seen before each rise.
    task automatic send_bits(input logic [31:0] w, input int nbits, input int half,
                             output logic [31:0] so_word);
        so_word = '0;
        for (int i = 31; i > 31 - nbits; i--) begin
            bus.spi_mosi = w[i];
            wait_clk(half);
            so_word = {so_word[30:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            wait_clk(half);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic open_frame();
        bus.spi_csn = 1'b0;
        wait_clk(4);
        wv_base = wv_count;
        fe_base = fe_count;
    endtask

    task automatic close_frame();
        wait_clk(4);
        bus.spi_csn = 1'b1;
        wait_clk(5);
    endtask

    logic [31:0] so;
    logic [31:0] rnd0;
    logic [31:0] rnd1;

    initial begin
        checks = 0;
        failures = 0;
        wv_count = 0;
        fe_count = 0;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_csn  = 1'b1;
        bus.tx_data  = 32'h0;
        nreset = 1'b0;
        wait_clk(3);
        nreset = 1'b1;
        wait_clk(2);

        check("rst_csn_sync", 32'(bus.csn_sync), 32'h1);
        check("rst_bit_cnt", 32'(bus.bit_cnt), 32'h0);
        check("rst_rx_data", bus.rx_data, 32'h0);
        check("rst_miso_oe", 32'(bus.spi_miso_oe), 32'h0);
        check("rst_miso", 32'(bus.spi_miso), 32'h0);

        // Write frame: address word then one data word.
        open_frame();
        check("wr_csn_sync", 32'(bus.csn_sync), 32'h0);
        check("wr_miso_oe", 32'(bus.spi_miso_oe), 32'h1);
        send_bits(32'h00000010, 32, 4, so);
        check("wr_cnt32", 32'(bus.bit_cnt), 32'd32);
        check("wr_addr", bus.rx_data, 32'h00000010);
        send_bits(32'hA1B2C3D4, 32, 4, so);
        check("wr_cnt64", 32'(bus.bit_cnt), 32'd64);
        check("wr_data", bus.rx_data, 32'hA1B2C3D4);
        close_frame();
        check("wr_wv_pulses", 32'(wv_count - wv_base), 32'd2);
        check("wr_no_error", 32'(fe_count - fe_base), 32'd0);
        check("wr_end_cnt", 32'(bus.bit_cnt), 32'd0);
        check("wr_end_oe", 32'(bus.spi_miso_oe), 32'h0);
        check("wr_end_rx_kept", bus.rx_data, 32'hA1B2C3D4);

        // Read frame: tx_data changes after the load fall must not leak out.
        bus.tx_data = 32'hDEADBEEF;
        open_frame();
        send_bits(32'h80000020, 32, 4, so);
        check("rd_addr_miso", so, 32'h0);
        check("rd_addr", bus.rx_data, 32'h80000020);
        wait_clk(4);
        bus.tx_data = 32'h0;
        send_bits(32'h0, 32, 4, so);
        check("rd_data_miso", so, 32'hDEADBEEF);
        close_frame();
        check("rd_idle_miso", 32'(bus.spi_miso), 32'h0);

        // Burst: address plus three data words.
        open_frame();
        send_bits(32'h00000004, 32, 4, so);
        check("bu_cnt_a", 32'(bus.bit_cnt), 32'd32);
        send_bits(32'h11111111, 32, 4, so);
        check("bu_cnt_w1", 32'(bus.bit_cnt), 32'd64);
        check("bu_w1", bus.rx_data, 32'h11111111);
        send_bits(32'h22222222, 32, 4, so);
        check("bu_cnt_w2", 32'(bus.bit_cnt), 32'd64);
        check("bu_w2", bus.rx_data, 32'h22222222);
        send_bits(32'h33333333, 1, 4, so);
        check("bu_cnt_wrap", 32'(bus.bit_cnt), 32'd33);
        send_bits(32'h66666666, 31, 4, so);
        check("bu_cnt_w3", 32'(bus.bit_cnt), 32'd64);
        check("bu_w3", bus.rx_data, 32'h33333333);
        close_frame();
        check("bu_wv_pulses", 32'(wv_count - wv_base), 32'd4);

        // Abort after 40 bits.
        open_frame();
        send_bits(32'h12345678, 32, 4, so);
        send_bits(32'hFF000000, 8, 4, so);
        check("ab_cnt40", 32'(bus.bit_cnt), 32'd40);
        close_frame();
        check("ab_error", 32'(fe_count - fe_base), 32'd1);
        check("ab_cnt", 32'(bus.bit_cnt), 32'd0);
        check("ab_rx_kept", bus.rx_data, 32'h12345678);
        check("ab_wv_pulses", 32'(wv_count - wv_base), 32'd1);

        // csn rise together with a sclk rise: the bit is discarded, no error.
        open_frame();
        send_bits(32'hCAFEF00D, 32, 4, so);
        bus.spi_mosi = 1'b1;
        wait_clk(4);
        bus.spi_sclk = 1'b1;
        bus.spi_csn  = 1'b1;
        wait_clk(4);
        bus.spi_sclk = 1'b0;
        wait_clk(4);
        check("co_cnt", 32'(bus.bit_cnt), 32'd0);
        check("co_error", 32'(fe_count - fe_base), 32'd0);
        check("co_rx", bus.rx_data, 32'hCAFEF00D);
        check("co_wv_pulses", 32'(wv_count - wv_base), 32'd1);

        // sclk toggling while deselected is ignored.
        send_bits(32'hFFFFFFFF, 3, 4, so);
        wait_clk(4);
        check("idle_cnt", 32'(bus.bit_cnt), 32'd0);
        check("idle_csn_sync", 32'(bus.csn_sync), 32'h1);

        // Minimum ratio: clock = 4x sclk with random data.
        rnd0 = $urandom;
        rnd1 = $urandom;
        open_frame();
        send_bits(rnd0, 32, 2, so);
        wait_clk(3);
        check("r4_w0", bus.rx_data, rnd0);
        send_bits(rnd1, 32, 2, so);
        wait_clk(3);
        check("r4_w1", bus.rx_data, rnd1);
        check("r4_cnt", 32'(bus.bit_cnt), 32'd64);
        close_frame();
        check("r4_wv_pulses", 32'(wv_count - wv_base), 32'd2);

        // Reset mid-frame clears everything at once.
        open_frame();
        send_bits(32'hF0F0F0F0, 10, 4, so);
        nreset = 1'b0;
        #1;
        check("mr_cnt", 32'(bus.bit_cnt), 32'd0);
        check("mr_oe", 32'(bus.spi_miso_oe), 32'h0);
        check("mr_rx", bus.rx_data, 32'h0);
        check("mr_csn_sync", 32'(bus.csn_sync), 32'h1);
        bus.spi_csn = 1'b1;
        wait_clk(2);
        nreset = 1'b1;
        wait_clk(5);
        check("mr_stays_idle", 32'(bus.csn_sync), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
